// File: rtl/set_bit_walker_if.sv
// Handshake bundle for set_bit_walker: upstream word/valid/ready and the
// downstream one-hot beat stream. The DUT uses the slave modport; the
// producer/consumer side uses master.
interface set_bit_walker_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
);

  // Upstream word channel
  logic [WIDTH-1:0] data_i;
  logic             data_val_i;
  logic             ready_o;

  // Downstream beat channel
  logic [WIDTH-1:0] onehot_o;
  logic [IDX_W-1:0] index_o;
  logic             data_val_o;
  logic             last_o;
  logic             ready_i;

  modport slave (
    input  data_i,
    input  data_val_i,
    output ready_o,
    output onehot_o,
    output index_o,
    output data_val_o,
    output last_o,
    input  ready_i
  );

  modport master (
    output data_i,
    output data_val_i,
    input  ready_o,
    input  onehot_o,
    input  index_o,
    input  data_val_o,
    input  last_o,
    output ready_i
  );

endinterface

// File: rtl/set_bit_walker.sv
// set_bit_walker: accepts a word and emits each of its set bits as a separate
// one-hot beat with a binary index and a last flag, MSB-first.
// Optional build macro SET_BIT_WALKER_LSB_FIRST_EN switches the walk order to
// LSB-first; handshake, latency and reset behaviour are unchanged.
module set_bit_walker #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input logic             clk_i,
  input logic             arst_n_i,
  set_bit_walker_if.slave bus
);

  typedef enum logic [0:0] {
    StIdle,
    StWalk
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] residual_q;
  logic [WIDTH-1:0] onehot_q;
  logic [IDX_W-1:0] index_q;
  logic             last_q;

  // Selection source and the bit picked from it for the next beat
  logic [WIDTH-1:0] pick_src;
  logic [WIDTH-1:0] pick_onehot;
  logic [IDX_W-1:0] pick_index;
  logic             pick_single;

  logic accept;
  logic beat_done;

  assign accept    = (state_q == StIdle) && bus.data_val_i && (bus.data_i != '0);
  assign beat_done = (state_q == StWalk) && bus.ready_i;

  // Pick the next bit to present: from the incoming word when idle, otherwise
  // from the residual with the current beat's bit already removed.
  always_comb begin
    pick_src    = (state_q == StIdle) ? bus.data_i : (residual_q & ~onehot_q);
    pick_onehot = '0;
    pick_index  = '0;
`ifdef SET_BIT_WALKER_LSB_FIRST_EN
    // Scan downward so the lowest set bit is the final assignment.
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (pick_src[i]) begin
        pick_onehot    = '0;
        pick_onehot[i] = 1'b1;
        pick_index     = IDX_W'(i);
      end
    end
`else
    // Scan upward so the highest set bit is the final assignment.
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (pick_src[i]) begin
        pick_onehot    = '0;
        pick_onehot[i] = 1'b1;
        pick_index     = IDX_W'(i);
      end
    end
`endif
    // Exactly one bit set: nonzero and clearing the lowest set bit gives zero.
    pick_single = (pick_src != '0) && ((pick_src & (pick_src - WIDTH'(1))) == '0);
  end

  // Walk FSM with registered beat outputs
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q    <= StIdle;
      residual_q <= '0;
      onehot_q   <= '0;
      index_q    <= '0;
      last_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // A zero word is dropped: no load, stay idle.
          if (accept) begin
            state_q    <= StWalk;
            residual_q <= bus.data_i;
            onehot_q   <= pick_onehot;
            index_q    <= pick_index;
            last_q     <= pick_single;
          end
        end
        StWalk: begin
          if (beat_done) begin
            if (last_q) begin
              state_q    <= StIdle;
              residual_q <= '0;
              onehot_q   <= '0;
              index_q    <= '0;
              last_q     <= 1'b0;
            end else begin
              residual_q <= residual_q & ~onehot_q;
              onehot_q   <= pick_onehot;
              index_q    <= pick_index;
              last_q     <= pick_single;
            end
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Handshake flags decode straight from the state register.
  assign bus.ready_o    = (state_q == StIdle);
  assign bus.data_val_o = (state_q == StWalk);
  assign bus.onehot_o   = onehot_q;
  assign bus.index_o    = index_q;
  assign bus.last_o     = last_q;

endmodule

// File: tb/tb_set_bit_walker.sv
// Directed bench for set_bit_walker (WIDTH=8). The default build walks
// MSB-first; with SET_BIT_WALKER_LSB_FIRST_EN defined the LSB-first vectors run.
module tb_set_bit_walker;

  localparam int unsigned Width = 8;
  localparam int unsigned IdxW  = 3;

  logic clk;
  logic rst_n;

  set_bit_walker_if #(.WIDTH(Width), .IDX_W(IdxW)) bus ();

  set_bit_walker #(
    .WIDTH(Width),
    .IDX_W(IdxW)
  ) dut (
    .clk_i    (clk),
    .arst_n_i (rst_n),
    .bus      (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_beat(input string tag, input logic [7:0] oh, input int idx,
                            input logic last);
    check({tag, ".val"},    32'(bus.data_val_o), 32'd1);
    check({tag, ".ready"},  32'(bus.ready_o),    32'd0);
    check({tag, ".onehot"}, 32'(bus.onehot_o),   32'(oh));
    check({tag, ".index"},  32'(bus.index_o),    32'(idx));
    check({tag, ".last"},   32'(bus.last_o),     32'(last));
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".val"},    32'(bus.data_val_o), 32'd0);
    check({tag, ".ready"},  32'(bus.ready_o),    32'd1);
    check({tag, ".onehot"}, 32'(bus.onehot_o),   32'd0);
    check({tag, ".index"},  32'(bus.index_o),    32'd0);
    check({tag, ".last"},   32'(bus.last_o),     32'd0);
  endtask

  // Present one word for a single accept edge with downstream always ready.
  task automatic send(input logic [7:0] w);
    bus.data_i     = w;
    bus.data_val_i = 1'b1;
    tick();
    bus.data_val_i = 1'b0;
    bus.data_i     = 8'h00;
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.data_i     = 8'h00;
    bus.data_val_i = 1'b0;
    bus.ready_i    = 1'b1;
    tick();
    tick();
    check_idle("reset");
    rst_n = 1'b1;
    tick();
    check_idle("post_reset");

`ifdef SET_BIT_WALKER_LSB_FIRST_EN
    // LSB-first walk of 0x48: bit 3 then bit 6
    send(8'h48);
    check_beat("lsb48_b0", 8'h08, 3, 1'b0);
    tick();
    check_beat("lsb48_b1", 8'h40, 6, 1'b1);
    tick();
    check_idle("lsb48_end");

    // LSB-first walk of 0xC9: bits 0, 3, 6, 7
    send(8'hC9);
    check_beat("lsbc9_b0", 8'h01, 0, 1'b0);
    tick();
    check_beat("lsbc9_b1", 8'h08, 3, 1'b0);
    tick();
    check_beat("lsbc9_b2", 8'h40, 6, 1'b0);
    tick();
    check_beat("lsbc9_b3", 8'h80, 7, 1'b1);
    tick();
    check_idle("lsbc9_end");
`else
    // 1: two set bits, continuous ready
    send(8'h48);
    check_beat("t1_b0", 8'h40, 6, 1'b0);
    tick();
    check_beat("t1_b1", 8'h08, 3, 1'b1);
    tick();
    check_idle("t1_end");

    // 2: first beat held under backpressure, then drained
    bus.ready_i = 1'b0;
    send(8'hC9);
    for (int k = 0; k < 4; k++) begin
      check_beat($sformatf("t2_hold%0d", k), 8'h80, 7, 1'b0);
      if (k == 3) bus.ready_i = 1'b1;
      tick();
    end
    check_beat("t2_b1", 8'h40, 6, 1'b0);
    tick();
    check_beat("t2_b2", 8'h08, 3, 1'b0);
    tick();
    check_beat("t2_b3", 8'h01, 0, 1'b1);
    tick();
    check_idle("t2_end");

    // 3: zero word dropped, immediate follow-up accepted
    send(8'h00);
    check_idle("t3_zero");
    send(8'h10);
    check_beat("t3_b0", 8'h10, 4, 1'b1);
    tick();
    check_idle("t3_end");

    // 4: asynchronous reset mid-walk after three beats transfer
    send(8'hFF);
    check_beat("t4_b0", 8'h80, 7, 1'b0);
    tick();
    check_beat("t4_b1", 8'h40, 6, 1'b0);
    tick();
    check_beat("t4_b2", 8'h20, 5, 1'b0);
    tick();
    check_beat("t4_b3", 8'h10, 4, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("t4_async");
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_idle($sformatf("t4_after%0d", k));
    end

    // 5: back-to-back words with data_val_i held high; data_i ignored in WALK
    bus.data_i     = 8'h06;
    bus.data_val_i = 1'b1;
    tick();
    bus.data_i = 8'h80;
    check_beat("t5_b0", 8'h04, 2, 1'b0);
    tick();
    check_beat("t5_b1", 8'h02, 1, 1'b1);
    tick();
    check_idle("t5_gap");
    tick();
    bus.data_val_i = 1'b0;
    bus.data_i     = 8'h00;
    check_beat("t5_b2", 8'h80, 7, 1'b1);
    tick();
    check_idle("t5_end");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
